// File: rtl/xmem_pkg.sv
// Shared types and constants for the external-memory arbiter.
package xmem_pkg;

  // Controller phases of one memory transfer.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR_SETUP,
    ST_WR,
    ST_GRACE
  } state_t;

  // Arbitration policies.
  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  // Byte-lane count for a data width that is a multiple of 8.
  function automatic int nbe_of(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/xmem_rr_pick.sv
// Combinational one-hot requester selector: fixed priority or round-robin.
module xmem_rr_pick
  import xmem_pkg::*;
#(
  parameter int NCH = 4,
  parameter int LGW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [LGW-1:0] last_grant,
  input  logic           mode,
  output logic [NCH-1:0] pick,
  output logic [LGW-1:0] pick_idx
);

  logic           found;
  int             idx;
  logic [LGW-1:0] sel;

  // Round-robin scans upward from last_grant+1 with wrap; fixed takes lowest index.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    idx      = 0;
    sel      = '0;
    if (mode == 1'(RR_ROUND)) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = int'(last_grant) + k;
        if (idx >= NCH) idx = idx - NCH;
        sel = LGW'(idx);
        if (!found && req[sel]) begin
          found     = 1'b1;
          pick[sel] = 1'b1;
          pick_idx  = sel;
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        sel = LGW'(i);
        if (!found && req[sel]) begin
          found     = 1'b1;
          pick[sel] = 1'b1;
          pick_idx  = sel;
        end
      end
    end
  end

endmodule

// File: rtl/xmem_arbiter.sv
// Multi-channel arbiter and timing engine for an asynchronous SRAM-style port.
module xmem_arbiter
  import xmem_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int RR      = 0,
  localparam int NBE    = nbe_of(DW),
  localparam int LGW    = $clog2(NCH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NCH-1:0]     req_valid,
  input  logic [NCH-1:0]     req_we,
  input  logic [NCH*AW-1:0]  req_addr,
  input  logic [NCH*DW-1:0]  req_wdata,
  input  logic [NCH*NBE-1:0] req_be_n,
  output logic [NCH-1:0]     req_ack,
  output logic [DW-1:0]      rdata,
  output logic [NCH-1:0]     grant,
  output logic [AW-1:0]      mem_adr,
  output logic [DW-1:0]      mem_dat_out,
  input  logic [DW-1:0]      mem_dat_in,
  output logic               mem_dat_drive,
  output logic               mem_ce_n,
  output logic               mem_oe_n,
  output logic               mem_we_n,
  output logic [NBE-1:0]     mem_be_n,
  output logic               addr_strobe,
  input  logic               memory_busy,
  input  logic               use_memory_busy
);

  localparam logic [3:0] RD_CNT = 4'(RD_WAIT);
  localparam logic [3:0] WR_CNT = 4'(WR_WAIT);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [LGW-1:0]   last_q, last_d;
  logic [NCH-1:0]   grant_q, grant_d;
  logic [NCH-1:0]   ack_q, ack_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [AW-1:0]    adr_q, adr_d;
  logic [DW-1:0]    wdat_q, wdat_d;
  logic [NBE-1:0]   be_q, be_d;
  logic             ce_q, ce_d;
  logic             oe_q, oe_d;
  logic             we_q, we_d;
  logic             drive_q, drive_d;
  logic             astb_q, astb_d;

  logic [NCH-1:0]   pick;
  logic [LGW-1:0]   pick_idx;
  logic [AW-1:0]    win_adr;
  logic [DW-1:0]    win_wdat;
  logic [NBE-1:0]   win_be;
  logic             win_we;
  logic             stall;

  xmem_rr_pick #(.NCH(NCH), .LGW(LGW)) u_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .mode       (RR != 0),
    .pick       (pick),
    .pick_idx   (pick_idx)
  );

  assign stall = use_memory_busy & memory_busy;

  // Route the winning channel's address, data and byte enables.
  always_comb begin
    win_adr  = '0;
    win_wdat = '0;
    win_be   = '1;
    win_we   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (pick[i]) begin
        win_adr  = req_addr[i*AW +: AW];
        win_wdat = req_wdata[i*DW +: DW];
        win_be   = req_be_n[i*NBE +: NBE];
        win_we   = req_we[i];
      end
    end
  end

  // Next-state and registered-output computation for the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    rdata_d = rdata_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    be_d    = be_q;
    ce_d    = ce_q;
    oe_d    = oe_q;
    we_d    = we_q;
    drive_d = drive_q;
    astb_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_valid) begin
          grant_d = pick;
          last_d  = pick_idx;
          adr_d   = win_adr;
          be_d    = win_be;
          ce_d    = 1'b0;
          astb_d  = 1'b1;
          if (win_we) begin
            wdat_d  = win_wdat;
            drive_d = 1'b1;
            state_d = ST_WR_SETUP;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = RD_CNT;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!stall) begin
          rdata_d = mem_dat_in;
          ce_d    = 1'b1;
          oe_d    = 1'b1;
          be_d    = '1;
          ack_d   = grant_q;
          grant_d = '0;
          state_d = ST_GRACE;
        end
      end
      ST_WR_SETUP: begin
        we_d    = 1'b0;
        cnt_d   = WR_CNT;
        state_d = ST_WR;
      end
      ST_WR: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (!stall) begin
          we_d    = 1'b1;
          ce_d    = 1'b1;
          drive_d = 1'b0;
          be_d    = '1;
          ack_d   = grant_q;
          grant_d = '0;
          state_d = ST_GRACE;
        end
      end
      ST_GRACE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        ce_d    = 1'b1;
        oe_d    = 1'b1;
        we_d    = 1'b1;
        drive_d = 1'b0;
        grant_d = '0;
      end
    endcase
  end

  // Sequencer state and all pin-facing registers; reset abandons any transfer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= LGW'(NCH - 1);
      grant_q <= '0;
      ack_q   <= '0;
      rdata_q <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      be_q    <= '1;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      drive_q <= 1'b0;
      astb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      be_q    <= be_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      we_q    <= we_d;
      drive_q <= drive_d;
      astb_q  <= astb_d;
    end
  end

  assign req_ack       = ack_q;
  assign rdata         = rdata_q;
  assign grant         = grant_q;
  assign mem_adr       = adr_q;
  assign mem_dat_out   = wdat_q;
  assign mem_dat_drive = drive_q;
  assign mem_ce_n      = ce_q;
  assign mem_oe_n      = oe_q;
  assign mem_we_n      = we_q;
  assign mem_be_n      = be_q;
  assign addr_strobe   = astb_q;

endmodule

// File: tb/tb_xmem_arbiter.sv
// Directed bench: fixed-priority instance (f_) and round-robin instance (r_) on shared inputs.
module tb_xmem_arbiter;

  localparam int NCH = 4, AW = 18, DW = 16, NBE = 2;

  logic clock, reset;
  logic [NCH-1:0]     req_valid, req_we;
  logic [NCH*AW-1:0]  req_addr;
  logic [NCH*DW-1:0]  req_wdata;
  logic [NCH*NBE-1:0] req_be_n;
  logic [DW-1:0]      mem_dat_in;
  logic               memory_busy, use_memory_busy;

  logic [NCH-1:0] f_ack, f_grant, r_ack, r_grant;
  logic [DW-1:0]  f_rdata, f_dout, r_rdata, r_dout;
  logic [AW-1:0]  f_adr, r_adr;
  logic [NBE-1:0] f_be, r_be;
  logic f_drive, f_ce, f_oe, f_we, f_astb;
  logic r_drive, r_ce, r_oe, r_we, r_astb;

  xmem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_WAIT(1), .WR_WAIT(2), .RR(0)) u_fix (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be_n(req_be_n),
    .req_ack(f_ack), .rdata(f_rdata), .grant(f_grant), .mem_adr(f_adr),
    .mem_dat_out(f_dout), .mem_dat_in(mem_dat_in), .mem_dat_drive(f_drive),
    .mem_ce_n(f_ce), .mem_oe_n(f_oe), .mem_we_n(f_we), .mem_be_n(f_be),
    .addr_strobe(f_astb), .memory_busy(memory_busy), .use_memory_busy(use_memory_busy));

  xmem_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_WAIT(1), .WR_WAIT(2), .RR(1)) u_rr (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be_n(req_be_n),
    .req_ack(r_ack), .rdata(r_rdata), .grant(r_grant), .mem_adr(r_adr),
    .mem_dat_out(r_dout), .mem_dat_in(mem_dat_in), .mem_dat_drive(r_drive),
    .mem_ce_n(r_ce), .mem_oe_n(r_oe), .mem_we_n(r_we), .mem_be_n(r_be),
    .addr_strobe(r_astb), .memory_busy(memory_busy), .use_memory_busy(use_memory_busy));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One record per cycle: drop = release req_valid after sampling this cycle.
  typedef struct {
    logic       drop;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [4:0] strb;   // {ce_n, oe_n, we_n, drive, addr_strobe}
    logic [1:0] be;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    memory_busy = 1'b0;
    use_memory_busy = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NBE-1:0] be);
    req_we[ch] = we;
    req_addr[ch*AW +: AW] = a;
    req_wdata[ch*DW +: DW] = d;
    req_be_n[ch*NBE +: NBE] = be;
    req_valid[ch] = 1'b1;
  endtask

  // Walk table entries first..last, one cycle each, against the fixed instance.
  task automatic play(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      step();
      chk($sformatf("vec%0d grant", i), 32'(f_grant), 32'(tbl[i].grant));
      chk($sformatf("vec%0d ack", i), 32'(f_ack), 32'(tbl[i].ack));
      chk($sformatf("vec%0d strobes", i), 32'({f_ce, f_oe, f_we, f_drive, f_astb}), 32'(tbl[i].strb));
      chk($sformatf("vec%0d be_n", i), 32'(f_be), 32'(tbl[i].be));
      if (tbl[i].drop) req_valid = '0;
    end
  endtask

  int cyc, ng, nf, ack_cyc, oe_low, acks;
  logic [3:0] gord[8];
  logic [3:0] ford[8];
  int gcyc[8];

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be_n = '1;
    mem_dat_in = 16'hBEEF; memory_busy = 1'b0; use_memory_busy = 1'b0; reset = 1'b1;

    // Read ch2 (cycles 1..5) then write ch1 (cycles 1..6).
    tbl[0]  = '{1'b0, 4'h4, 4'h0, 5'b00101, 2'b00};
    tbl[1]  = '{1'b0, 4'h4, 4'h0, 5'b00100, 2'b00};
    tbl[2]  = '{1'b1, 4'h0, 4'h4, 5'b11100, 2'b11};
    tbl[3]  = '{1'b0, 4'h0, 4'h0, 5'b11100, 2'b11};
    tbl[4]  = '{1'b0, 4'h0, 4'h0, 5'b11100, 2'b11};
    tbl[5]  = '{1'b0, 4'h2, 4'h0, 5'b01111, 2'b10};
    tbl[6]  = '{1'b0, 4'h2, 4'h0, 5'b01010, 2'b10};
    tbl[7]  = '{1'b0, 4'h2, 4'h0, 5'b01010, 2'b10};
    tbl[8]  = '{1'b0, 4'h2, 4'h0, 5'b01010, 2'b10};
    tbl[9]  = '{1'b1, 4'h0, 4'h2, 5'b11100, 2'b11};
    tbl[10] = '{1'b0, 4'h0, 4'h0, 5'b11100, 2'b11};

    do_reset();
    chk("rst strobes", 32'({f_ce, f_oe, f_we, f_drive, f_astb}), 32'b11100);
    chk("rst be_n", 32'(f_be), 32'h3);
    chk("rst grant", 32'(f_grant), 32'h0);
    chk("rst ack", 32'(f_ack), 32'h0);
    chk("rst adr", 32'(f_adr), 32'h0);
    chk("rst rdata", 32'(f_rdata), 32'h0);

    // Single read and single write.
    set_req(2, 1'b0, 18'h12345, 16'h0000, 2'b00);
    step();
    chk("rd adr", 32'(f_adr), 32'h12345);
    chk("rd c1 oe", 32'(f_oe), 32'h0);
    play(1, 4);
    chk("rd rdata", 32'(f_rdata), 32'hBEEF);
    set_req(1, 1'b1, 18'h00321, 16'hA55A, 2'b10);
    mem_dat_in = 16'h0F0F;
    play(5, 10);
    chk("wr adr", 32'(f_adr), 32'h00321);
    chk("wr dat", 32'(f_dout), 32'hA55A);
    chk("rdata held", 32'(f_rdata), 32'hBEEF);

    // Fixed priority: ch0 and ch3 together.
    do_reset();
    set_req(0, 1'b0, 18'h00100, 16'h0, 2'b00);
    set_req(3, 1'b0, 18'h00300, 16'h0, 2'b00);
    cyc = 0; ng = 0;
    while (ng < 2 && cyc < 40) begin
      step(); cyc++;
      if (f_astb) begin
        gord[ng] = f_grant; gcyc[ng] = cyc; ng++;
        if (ng == 2) chk("fp ch3 adr", 32'(f_adr), 32'h00300);
      end
      if (|(f_ack & req_valid)) req_valid = req_valid & ~f_ack;
    end
    chk("fp grants seen", 32'(ng), 32'd2);
    chk("fp first", 32'(gord[0]), 32'h1);
    chk("fp second", 32'(gord[1]), 32'h8);
    chk("fp first cycle", 32'(gcyc[0]), 32'd1);
    chk("fp second cycle", 32'(gcyc[1]), 32'd5);

    // Round-robin rotation with all channels requesting continuously.
    do_reset();
    for (int c = 0; c < NCH; c++) set_req(c, 1'b0, AW'(c * 16), 16'h0, 2'b00);
    cyc = 0; ng = 0; nf = 0;
    while (ng < 5 && cyc < 60) begin
      step(); cyc++;
      if (r_astb) begin gord[ng] = r_grant; ng++; end
      if (f_astb && nf < 8) begin ford[nf] = f_grant; nf++; end
    end
    chk("rr grants seen", 32'(ng), 32'd5);
    chk("rr order", 32'({gord[0], gord[1], gord[2], gord[3], gord[4]}), 32'h12481);
    chk("fixed starves others", 32'({ford[0], ford[1]}), 32'h11);

    // Stall: busy high for 5 edges once the read counter has expired.
    do_reset();
    mem_dat_in = 16'h1357;
    use_memory_busy = 1'b1;
    set_req(1, 1'b0, 18'h02AAA, 16'h0, 2'b00);
    cyc = 0; ack_cyc = 0; oe_low = 0;
    while (ack_cyc == 0 && cyc < 30) begin
      step(); cyc++;
      if (f_ack != 4'h0) begin
        ack_cyc = cyc;
        chk("stall ack ch", 32'(f_ack), 32'h2);
        chk("stall rdata", 32'(f_rdata), 32'h1357);
        req_valid = '0;
      end else if (!f_oe && !f_ce) oe_low++;
      if (cyc == 2) memory_busy = 1'b1;
      if (cyc == 7) memory_busy = 1'b0;
    end
    chk("stall ack cycle", 32'(ack_cyc), 32'd8);
    chk("stall strobes held", 32'(oe_low), 32'd7);

    // Reset in the middle of a write.
    do_reset();
    set_req(0, 1'b1, 18'h3FFFF, 16'h1234, 2'b00);
    step(); step(); step();
    chk("mid-wr we low", 32'(f_we), 32'h0);
    reset = 1'b1;
    step();
    chk("rst-wr strobes", 32'({f_ce, f_oe, f_we, f_drive}), 32'b1110);
    chk("rst-wr grant", 32'(f_grant), 32'h0);
    chk("rst-wr ack", 32'(f_ack), 32'h0);
    reset = 1'b0;
    req_valid = '0;
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (f_ack != 4'h0 || !f_ce) acks++;
    end
    chk("rst-wr no ack after", 32'(acks), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xmem_arbiter.md
# xmem_arbiter

Parametrised external-memory controller that arbitrates NCH independent requesters (CPU, VDP, loaders, DMA) onto one asynchronous SRAM-style port. It replaces the fixed-channel, fixed-timing controller with configurable address/data width, per-operation wait states, selectable priority policy and arbitrary byte enables. It sits between the system bus masters and the external memory pins, or the FPGA-side memory wrapper.

## Interface
Parameters:
- NCH, 4, number of requester channels (2..8); channel 0 has highest fixed priority
- AW, 18, word address width
- DW, 16, data width, multiple of 8; NBE = DW/8
- RD_WAIT, 1, extra cycles between strobe assertion and read-data capture (0..15)
- WR_WAIT, 1, extra cycles of WE low (0..15)
- RR, 0, 0 = fixed priority, 1 = round-robin

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- req_valid  in  NCH  per-channel request; held until ack
- req_we  in  NCH  1 = write, 0 = read
- req_addr  in  NCH*AW  flattened; channel i at [i*AW +: AW]
- req_wdata  in  NCH*DW  flattened write data
- req_be_n  in  NCH*NBE  active-low byte enables
- req_ack  out  NCH  one-cycle completion pulse
- rdata  out  DW  read data, valid while req_ack high, held until next read
- grant  out  NCH  one-hot owner of the current cycle, 0 when idle
- mem_adr  out  AW,  mem_dat_out  out  DW,  mem_dat_in  in  DW
- mem_dat_drive  out  1  pad output enable
- mem_ce_n / mem_oe_n / mem_we_n  out  1  active-low strobes
- mem_be_n  out  NBE  active-low byte enables
- addr_strobe  out  1  one-cycle pulse when mem_adr changes
- memory_busy  in  1,  use_memory_busy  in  1  external stall

## Operation
- States: IDLE, RD, WR_SETUP, WR, GRACE.
- IDLE: req_valid sampled only here. Winner: RR=0 lowest index; RR=1 first set bit searching from last_grant+1, wrapping at NCH-1. Winner's addr, be_n and (for writes) wdata are registered; addr_strobe pulses; grant set.
- Read grant: ce_n=0, oe_n=0, counter=RD_WAIT, go RD. RD: counter>0 decrements; at 0, if !(use_memory_busy && memory_busy), capture mem_dat_in to rdata, release ce_n/oe_n, pulse ack, go GRACE; otherwise hold.
- Write grant: ce_n=0, mem_dat_drive=1, we_n still 1, go WR_SETUP. WR_SETUP: we_n=0, counter=WR_WAIT, go WR. WR: count down as in RD; at 0 and not stalled, we_n=1, ce_n=1, drive=0, pulse ack, go GRACE.
- GRACE: all strobes high, grant=0, go IDLE. The requester must drop or change req_valid by the cycle after ack.
- last_grant updates only on grant. Simultaneous requests are resolved solely by policy; a losing request stays pending with no loss.
- Reset values: state IDLE, ce_n/oe_n/we_n=1, mem_be_n all 1, mem_dat_drive=0, req_ack=0, grant=0, addr_strobe=0, mem_adr=0, rdata=0, last_grant=NCH-1.
- Reset mid-transaction: strobes go inactive at the next edge, the transfer is abandoned, and no ack is issued.
- req_valid dropping before ack is illegal and not checked.

## Timing
- Cycle 0 = IDLE edge that samples req_valid. Strobes and address are visible from cycle 1.
- Read ack high in cycle RD_WAIT+2 with no stalls; the next grant is possible in cycle RD_WAIT+4.
- Write: WE low in cycles 2..WR_WAIT+2; ack high in cycle WR_WAIT+3; the next grant is possible in cycle WR_WAIT+5.
- Address, data and be_n are stable from cycle 1 until strobes deassert. mem_dat_drive never overlaps oe_n=0.
- Each stall cycle adds one cycle to ack latency.
- RR=1 with all channels requesting gives strict rotation, so worst-case wait is NCH-1 transactions.

## Structure
- Package xmem_pkg: state enum, RR policy constants, DW/NBE helper function.
- Sub-module xmem_rr_pick: combinational priority/round-robin one-hot selector (inputs req, last_grant, mode).
- Datapath muxes and the wait counter stay in the top level.

## Test plan
- Single read, NCH=4, RD_WAIT=1: ch2 reads 0x12345, mem_dat_in=0xBEEF → ack[2] in cycle 3, rdata=0xBEEF, oe_n low in cycles 1-2.
- Single write, WR_WAIT=2: ch1 writes 0xA55A, be_n=2'b10 → we_n low cycles 2-4, mem_be_n=2'b10, ack[1] in cycle 5, drive drops with ack.
- Fixed priority: ch0 and ch3 request together, RR=0 → ch0 served first, ch3 granted the IDLE after GRACE, no request lost.
- Round-robin: all four hold requests, RR=1 → grant order 0,1,2,3,0 after reset.
- Stall: use_memory_busy=1, memory_busy high 5 cycles during a read → ack delayed by exactly 5 cycles, strobes held.
- Reset asserted in WR → next cycle we_n=ce_n=1, drive=0, no ack, state IDLE.
